// File: rtl/dbus_sram_responder_if.sv
// Data request/response bus between the core (master) and a data memory (slave).
// One request outstanding: addr_ok accepts, data_ok completes.
interface dbus_sram_responder_if;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [31:0] dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/dbus_sram_responder.sv
// Word-organised SRAM behind the data bus; data_ok LATENCY cycles after addr_ok.
// Single outstanding request: addr_ok is withheld until the response cycle has passed.
module dbus_sram_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    dbus_sram_responder_if.slave dbus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [3:0]            strobe_q;
    logic [31:0]           data_q;
    logic [31:0]           mem [0:(1<<ADDR_WIDTH)-1];
    logic                  in_resp;

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dbus.dreq_addr[31:ADDR_WIDTH+2], dbus.dreq_addr[1:0]};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (dbus.dreq_valid) begin
                    accept    = 1'b1;
                    cnt_nxt   = LAT_M1;
                    state_nxt = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            idx_q    <= '0;
            strobe_q <= 4'd0;
            data_q   <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                idx_q    <= dbus.dreq_addr[ADDR_WIDTH+1:2];
                strobe_q <= dbus.dreq_strobe;
                data_q   <= dbus.dreq_data;
            end
        end
    end

    // Outputs are gated by resetn so nothing leaks out while reset is held.
    assign in_resp = (state == RESP) && resetn;

    // Write commits on the edge that ends RESP, before the next request can be taken.
    always_ff @(posedge clk) begin
        if (in_resp) begin
            for (int k = 0; k < 4; k++) begin
                if (strobe_q[k]) begin
                    mem[idx_q][8*k +: 8] <= data_q[8*k +: 8];
                end
            end
        end
    end

    assign dbus.dresp_addr_ok = accept && resetn;
    assign dbus.dresp_data_ok = in_resp;
    assign dbus.dresp_data    = (in_resp && (strobe_q == 4'd0)) ? mem[idx_q] : 32'h0;
endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: streamed vector table with a response scoreboard on
// a LATENCY=2 instance, plus hand sequences on LATENCY=1 and LATENCY=3 instances.
module tb_dbus_sram_responder;
    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dbus_sram_responder_if m ();
    dbus_sram_responder_if if1 ();
    dbus_sram_responder_if if3 ();

    dbus_sram_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut  (.clk(clk), .resetn(resetn), .dbus(m.slave));
    dbus_sram_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (.clk(clk), .resetn(resetn), .dbus(if1.slave));
    dbus_sram_responder #(.ADDR_WIDTH(10), .LATENCY(3)) u_dut3 (.clk(clk), .resetn(resetn), .dbus(if3.slave));

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Drives a request, waits for acceptance, optionally books the expected response.
    task automatic send(input vec_t v, input bit book, output int acc);
        m.dreq_valid  = 1'b1;
        m.dreq_addr   = v.addr;
        m.dreq_strobe = v.strobe;
        m.dreq_data   = v.wdata;
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m.dresp_addr_ok) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else if (book) begin
            exp_q.push_back('{v.rexp, acc + 2});
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (m.dresp_data_ok) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_data_ok", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_data", m.dresp_data, e.data);
                    chk("resp_cycle", 32'(cyc), 32'(e.due));
                    chk("no_overlap", 32'(m.dresp_addr_ok), 32'd0);
                end
            end else begin
                chk("idle_data_zero", m.dresp_data, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   acc, prev, rel, nok;
        vec_t v;

        vecs.push_back('{32'h0000_0040, 4'hF, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{32'h0000_0040, 4'h0, 32'h0,        32'hDEADBEEF});
        vecs.push_back('{32'h0000_0080, 4'hF, 32'h11223344, 32'h0});
        vecs.push_back('{32'h0000_0080, 4'h4, 32'h00AA0000, 32'h0});
        vecs.push_back('{32'h0000_0080, 4'h1, 32'h000000BB, 32'h0});
        vecs.push_back('{32'h0000_0080, 4'h0, 32'h0,        32'h11AA33BB});
        vecs.push_back('{32'h0000_0010, 4'hF, 32'hFFFFFFFF, 32'h0});
        vecs.push_back('{32'h0000_0010, 4'hC, 32'h12340000, 32'h0});
        vecs.push_back('{32'h0000_0010, 4'h0, 32'h0,        32'h1234FFFF});
        vecs.push_back('{32'h0000_0012, 4'hC, 32'h56780000, 32'h0});
        vecs.push_back('{32'h0000_0010, 4'h0, 32'h0,        32'h5678FFFF});
        vecs.push_back('{32'h0000_1044, 4'hF, 32'h0BADF00D, 32'h0});
        vecs.push_back('{32'h0000_0044, 4'h0, 32'h0,        32'h0BADF00D});
        vecs.push_back('{32'h0000_0044, 4'hA, 32'hAABBCCDD, 32'h0});
        vecs.push_back('{32'h0000_0047, 4'h0, 32'h0,        32'hAAADCC0D});
        vecs.push_back('{32'h0000_0020, 4'hF, 32'hCAFEF00D, 32'h0});
        vecs.push_back('{32'h0000_1020, 4'h0, 32'h0,        32'hCAFEF00D});

        // Reset held with a request already pending on the main instance.
        resetn = 1'b0;
        m.dreq_valid = 1'b1;  m.dreq_addr = vecs[0].addr;
        m.dreq_strobe = vecs[0].strobe;  m.dreq_data = vecs[0].wdata;
        if1.dreq_valid = 1'b0; if1.dreq_addr = 32'h0; if1.dreq_strobe = 4'h0; if1.dreq_data = 32'h0;
        if3.dreq_valid = 1'b0; if3.dreq_addr = 32'h0; if3.dreq_strobe = 4'h0; if3.dreq_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_addr_ok", 32'(m.dresp_addr_ok), 32'd0);
        chk("reset_data_ok", 32'(m.dresp_data_ok), 32'd0);
        chk("reset_data",    m.dresp_data, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        rel    = cyc;
        mon_en = 1'b1;

        // Back-to-back stream; dreq_* switch to the next vector while the previous is in flight.
        prev = 0;
        foreach (vecs[i]) begin
            send(vecs[i], 1'b1, acc);
            if (i == 0) chk("accept_after_reset", 32'(acc), 32'(rel));
            else        chk("accept_interval", 32'(acc - prev), 32'd3);
            prev = acc;
        end
        m.dreq_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Reset pulse while the write to 0x20 is in WAIT.
        v = '{32'h0000_0020, 4'hF, 32'h00000001, 32'h0};
        send(v, 1'b0, acc);
        m.dreq_valid = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        chk("midreset_addr_ok", 32'(m.dresp_addr_ok), 32'd0);
        chk("midreset_data_ok", 32'(m.dresp_data_ok), 32'd0);
        chk("midreset_data",    m.dresp_data, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        nok = 0;
        repeat (4) begin
            @(negedge clk);
            nok += int'(m.dresp_data_ok);
        end
        chk("no_resp_after_reset", 32'(nok), 32'd0);
        @(posedge clk);
        #1;
        v = '{32'h0000_0020, 4'h0, 32'h0, 32'hCAFEF00D};
        send(v, 1'b1, acc);
        m.dreq_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // LATENCY=1: write through an aliased address, read back at word 0.
        if1.dreq_valid = 1'b1; if1.dreq_addr = 32'h0000_1000;
        if1.dreq_strobe = 4'hF; if1.dreq_data = 32'h5A5A5A5A;
        @(negedge clk);
        chk("l1_wr_addr_ok", 32'(if1.dresp_addr_ok), 32'd1);
        chk("l1_wr_no_data_ok", 32'(if1.dresp_data_ok), 32'd0);
        @(posedge clk);
        #1;
        if1.dreq_addr = 32'h0; if1.dreq_strobe = 4'h0; if1.dreq_data = 32'h0;
        @(negedge clk);
        chk("l1_holdoff", 32'(if1.dresp_addr_ok), 32'd0);
        chk("l1_wr_data_ok", 32'(if1.dresp_data_ok), 32'd1);
        chk("l1_wr_data", if1.dresp_data, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("l1_rd_addr_ok", 32'(if1.dresp_addr_ok), 32'd1);
        chk("l1_rd_no_data_ok", 32'(if1.dresp_data_ok), 32'd0);
        @(posedge clk);
        #1;
        if1.dreq_valid = 1'b0;
        @(negedge clk);
        chk("l1_rd_data_ok", 32'(if1.dresp_data_ok), 32'd1);
        chk("l1_rd_data", if1.dresp_data, 32'h5A5A5A5A);
        @(posedge clk);
        #1;

        // LATENCY=3 with dreq_valid held: addr_ok every 4 cycles, data_ok 3 after each.
        if3.dreq_valid = 1'b1;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            chk("l3_addr_ok", 32'(if3.dresp_addr_ok), 32'((k % 4) == 0));
            chk("l3_data_ok", 32'(if3.dresp_data_ok), 32'((k % 4) == 3));
        end
        @(posedge clk);
        #1;
        if3.dreq_valid = 1'b0;
        repeat (2) @(posedge clk);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
